encode_pack: RTL and testbench
==============================

ENCODE_PACK -- requirements
Module: encode_pack

Interface
REQ-001 SHALL have parameter LZF_WIDTH, default 20, width of the output word counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  chip enable; when low, no code accepted and no word written.
REQ-005 code_valid  input  1  code word offered this cycle.
REQ-006 code  input  32  code bits, right-aligned; code[code_len-1] is the first bit on the stream.
REQ-007 code_len  input  6  number of valid bits, 0..32; 0 = no bits (marker only).
REQ-008 code_last  input  1  qualifies code_valid; final code of the stream.
REQ-009 code_ready  output  1  code accepted this cycle when code_valid & code_ready.
REQ-010 fo_full  input  1  output FIFO almost-full; guarantees at least one free slot while low.
REQ-011 fo_we  output  1  one-cycle write strobe for fo.
REQ-012 fo  output  64  packed output word, stream bit 0 at fo[63] (MSB-first).
REQ-013 word_cnt  output  LZF_WIDTH  number of fo_we pulses since reset.
REQ-014 done  output  1  stream completely flushed; sticky until reset.

Function
REQ-015 SHALL hold a 64-bit accumulator acc and fill count cnt (0..63); acc fills from bit 63 downward.
REQ-016 SHALL implement states S_RUN, S_FLUSH, S_DONE; reset state S_RUN.
REQ-017 code_ready SHALL be ce & !fo_full & (state==S_RUN), combinational.
REQ-018 On accept with cnt+len<64: code placed at acc[63-cnt : 64-cnt-len], cnt += len, no write.
REQ-019 On accept with cnt+len>=64: fo <= acc with the first 64-cnt code bits in acc[63-cnt:0], fo_we=1 next cycle; remainder r=cnt+len-64 bits (code[r-1:0]) placed at acc[63:64-r], all other acc bits zero, cnt=r.
REQ-020 Latency: fo and fo_we registered, valid on the cycle after the accepting edge; fo holds its value until the next write.
REQ-021 len=0 accept SHALL change neither acc nor cnt.
REQ-022 Accept with code_last: if resulting cnt>0 go S_FLUSH, else go S_DONE (any word completed by that code is still written per REQ-019).
REQ-023 S_FLUSH: when ce & !fo_full, write acc (unused low bits zero) with fo_we, clear acc/cnt, go S_DONE; otherwise wait.
REQ-024 S_DONE: code_ready=0, fo_we=0, done=1 from the first cycle in S_DONE until reset.
REQ-025 word_cnt SHALL increment by 1 on every fo_we, wrapping at 2^LZF_WIDTH.
REQ-026 Bits of code above code_len-1 SHALL be ignored; code_len>32 is illegal (no defined behaviour).
REQ-027 fo_full or ce low with a pending code: no accept, state and acc held, code must remain stable.

Reset
REQ-028 rst high at a clock edge SHALL force state=S_RUN, acc=0, cnt=0, fo=0, fo_we=0, word_cnt=0, done=0, regardless of state or in-flight code; the in-flight code is discarded.
REQ-029 code_ready SHALL be 0 during any cycle rst is high.

Verification
REQ-030 Eight codes len 8, values 0x01..0x08 -> single fo_we, fo=0x0102030405060708, word_cnt=1, cnt=0.
REQ-031 Codes (len30,0x0),(len30,0x0),(len8,0xA5), then (len0,last) -> fo=0x000000000000000A, then fo=0x5000000000000000, done=1, word_cnt=2.
REQ-032 Code 0x180 len 9 with code_last (LZS end marker) -> fo=0xC000000000000000, done=1, word_cnt=1.
REQ-033 Two len-32 codes 0xDEADBEEF, 0x01234567 (second with last) -> fo=0xDEADBEEF01234567, done=1 next cycle with no flush word, word_cnt=1.
REQ-034 fo_full high while code_valid held 10 cycles -> code_ready=0, no fo_we, acc unchanged; fo_full low -> accepted next edge.
REQ-035 rst pulsed after 3 accepted len-8 codes -> all outputs reset values; next 8 codes 0x11..0x88 produce fo=0x1122334455667788.

Source files
------------

// File: rtl/encode_pack_if.sv
// Code-stream and packed-word bus for the bit packer.
// The slave side is the packer itself: it takes codes in and drives packed
// words out. The master side is whatever feeds codes and owns the FIFO.
interface encode_pack_if;
  logic        code_valid;
  logic [31:0] code;
  logic [5:0]  code_len;
  logic        code_last;
  logic        code_ready;
  logic        fo_full;
  logic        fo_we;
  logic [63:0] fo;

  modport master (
    output code_valid, code, code_len, code_last, fo_full,
    input  code_ready, fo_we, fo
  );

  modport slave (
    input  code_valid, code, code_len, code_last, fo_full,
    output code_ready, fo_we, fo
  );
endinterface

// File: rtl/encode_pack.sv
// Variable-length code packer: concatenates right-aligned codes of 0..32 bits
// into an MSB-first bit stream and emits it as 64-bit words. The final
// partial word is flushed with zero padding once the last code is seen.
module encode_pack #(
  parameter int LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  encode_pack_if.slave         bus,
  output logic [LZF_WIDTH-1:0] word_cnt,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [63:0]          r_acc;
  logic [5:0]           r_cnt;
  logic [63:0]          r_fo;
  logic                 r_fo_we;
  logic [LZF_WIDTH-1:0] r_word_cnt;
  logic                 r_done;

  logic        w_ready;
  logic        w_accept;
  logic [31:0] w_mask;
  logic [31:0] w_code_m;
  logic [6:0]  w_sum;
  logic [7:0]  w_shift;
  logic [127:0] w_wide;

  // Ready is purely combinational so a producer sees it in the same cycle;
  // it is forced low while reset is held.
  assign w_ready  = ce & ~bus.fo_full & (r_state == S_RUN) & ~rst;
  assign w_accept = bus.code_valid & w_ready;

  // Strip any bits above code_len; a shift of 32 (len 0) yields an empty mask.
  assign w_mask   = 32'hFFFF_FFFF >> (6'd32 - bus.code_len);
  assign w_code_m = bus.code & w_mask;

  // The accumulator is treated as the top half of a 128-bit window. The code
  // is shifted so its first bit lands right after the filled region; the top
  // half is then either the new accumulator or a completed word, and the
  // bottom half holds any overflow bits already MSB-aligned and zero-padded.
  assign w_sum   = {1'b0, r_cnt} + {1'b0, bus.code_len};
  assign w_shift = 8'd128 - {1'b0, w_sum};
  assign w_wide  = {r_acc, 64'b0} | ({96'b0, w_code_m} << w_shift);

  // Packing state machine with registered outputs; a set word_cnt always
  // tracks the fo_we pulse it accompanies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_fo       <= '0;
      r_fo_we    <= 1'b0;
      r_word_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_fo_we <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            r_cnt <= w_sum[5:0];
            if (w_sum[6]) begin
              r_fo       <= w_wide[127:64];
              r_fo_we    <= 1'b1;
              r_word_cnt <= r_word_cnt + 1'b1;
              r_acc      <= w_wide[63:0];
            end else begin
              r_acc <= w_wide[127:64];
            end
            if (bus.code_last) begin
              if (w_sum[5:0] != 6'd0) begin
                r_state <= S_FLUSH;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          if (ce && !bus.fo_full) begin
            r_fo       <= r_acc;
            r_fo_we    <= 1'b1;
            r_word_cnt <= r_word_cnt + 1'b1;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= S_DONE;
            r_done     <= 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign bus.code_ready = w_ready;
  assign bus.fo_we      = r_fo_we;
  assign bus.fo         = r_fo;
  assign word_cnt       = r_word_cnt;
  assign done           = r_done;

endmodule

// File: tb/tb_encode_pack.sv
// Directed bench for encode_pack: expected packed words are queued when codes
// are driven and compared whenever the packer pulses fo_we.
module tb_encode_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [19:0] wordCnt;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ[$];

  encode_pack_if bus();

  encode_pack #(.LZF_WIDTH(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .bus      (bus.slave),
    .word_cnt (wordCnt),
    .done     (done)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued word.
  always @(negedge clk) begin
    if (bus.fo_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("fo_we_unexpected", 64'(expQ.size()), 64'd1);
      end else begin
        checkOutput("fo_word", bus.fo, expQ.pop_front());
      end
    end
  end

  // Offer one code and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [31:0] c, input logic [5:0] len, input logic last);
    bit accepted;
    bus.code       = c;
    bus.code_len   = len;
    bus.code_last  = last;
    bus.code_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.code_ready === 1'b1) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) checkOutput("accept_timeout", {63'b0, bus.code_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    bus.code_last  = 1'b0;
  endtask

  // Synchronous reset pulse, then verify every reset value.
  task automatic applyReset();
    rst            = 1'b1;
    ce             = 1'b1;
    bus.fo_full    = 1'b0;
    bus.code_valid = 1'b0;
    bus.code_last  = 1'b0;
    bus.code       = 32'h0;
    bus.code_len   = 6'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {63'b0, bus.code_ready}, 64'd0);
    checkOutput("rst_fo", bus.fo, 64'd0);
    checkOutput("rst_fo_we", {63'b0, bus.fo_we}, 64'd0);
    checkOutput("rst_word_cnt", {44'b0, wordCnt}, 64'd0);
    checkOutput("rst_done", {63'b0, done}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    applyReset();

    // Eight byte codes fill exactly one word; upper garbage bits are ignored.
    expQ.push_back(64'h0102030405060708);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus({24'hFFFFFF, 8'(i)} & ((i % 2 == 0) ? 32'hFFFFFFFF : 32'h000000FF), 6'd8, 1'b0);
    end
    waitCycles(2);
    checkOutput("bytes_word_cnt", {44'b0, wordCnt}, 64'd1);
    checkOutput("bytes_done", {63'b0, done}, 64'd0);
    checkOutput("bytes_ready", {63'b0, bus.code_ready}, 64'd1);

    // Word straddling plus zero-length final marker forcing a flush.
    applyReset();
    expQ.push_back(64'h000000000000000A);
    expQ.push_back(64'h5000000000000000);
    applyStimulus(32'h0, 6'd30, 1'b0);
    applyStimulus(32'h0, 6'd30, 1'b0);
    applyStimulus(32'hA5, 6'd8, 1'b0);
    applyStimulus(32'h0, 6'd0, 1'b1);
    waitCycles(3);
    checkOutput("straddle_done", {63'b0, done}, 64'd1);
    checkOutput("straddle_word_cnt", {44'b0, wordCnt}, 64'd2);
    checkOutput("straddle_ready_done", {63'b0, bus.code_ready}, 64'd0);

    // End marker alone, flushed as a padded word.
    applyReset();
    expQ.push_back(64'hC000000000000000);
    applyStimulus(32'h180, 6'd9, 1'b1);
    waitCycles(3);
    checkOutput("marker_done", {63'b0, done}, 64'd1);
    checkOutput("marker_word_cnt", {44'b0, wordCnt}, 64'd1);

    // Two full-width codes end exactly on a word boundary: no flush word.
    applyReset();
    expQ.push_back(64'hDEADBEEF01234567);
    applyStimulus(32'hDEADBEEF, 6'd32, 1'b0);
    applyStimulus(32'h01234567, 6'd32, 1'b1);
    checkOutput("exact_done_next", {63'b0, done}, 64'd1);
    waitCycles(4);
    checkOutput("exact_word_cnt", {44'b0, wordCnt}, 64'd1);

    // Back-pressure from fo_full and ce low holds the pending code.
    applyReset();
    expQ.push_back(64'hABCAFEBABE123456);
    applyStimulus(32'hAB, 6'd8, 1'b0);
    bus.fo_full    = 1'b1;
    bus.code       = 32'hCAFEBABE;
    bus.code_len   = 6'd32;
    bus.code_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("full_ready", {63'b0, bus.code_ready}, 64'd0);
    end
    bus.fo_full = 1'b0;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ce_ready", {63'b0, bus.code_ready}, 64'd0);
    end
    ce = 1'b1;
    #1;
    checkOutput("release_ready", {63'b0, bus.code_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    checkOutput("held_word_cnt", {44'b0, wordCnt}, 64'd0);
    applyStimulus(32'h123456, 6'd24, 1'b1);
    waitCycles(3);
    checkOutput("held_done", {63'b0, done}, 64'd1);
    checkOutput("held_word_cnt_end", {44'b0, wordCnt}, 64'd1);

    // Flush waits while the FIFO is full.
    applyReset();
    expQ.push_back(64'h9000000000000000);
    applyStimulus(32'h9, 6'd4, 1'b1);
    bus.fo_full = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("flush_wait_done", {63'b0, done}, 64'd0);
    end
    bus.fo_full = 1'b0;
    waitCycles(3);
    checkOutput("flush_done", {63'b0, done}, 64'd1);
    checkOutput("flush_word_cnt", {44'b0, wordCnt}, 64'd1);

    // Empty final marker with nothing pending goes straight to done.
    applyReset();
    applyStimulus(32'hFFFFFFFF, 6'd0, 1'b1);
    waitCycles(2);
    checkOutput("empty_done", {63'b0, done}, 64'd1);
    checkOutput("empty_word_cnt", {44'b0, wordCnt}, 64'd0);

    // Reset mid-word discards the partial accumulator.
    applyReset();
    applyStimulus(32'hAA, 6'd8, 1'b0);
    applyStimulus(32'hBB, 6'd8, 1'b0);
    applyStimulus(32'hCC, 6'd8, 1'b0);
    applyReset();
    expQ.push_back(64'h1122334455667788);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(32'(i * 17), 6'd8, 1'b0);
    end
    waitCycles(2);
    checkOutput("rereset_word_cnt", {44'b0, wordCnt}, 64'd1);

    waitCycles(4);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
